// File: rtl/intr_sched_if.sv
// Interrupt scheduler bus: device lines, CPU handshake and debug outputs.
// INTREQ/ACK handshake: INTREQ stays high until the processor answers with a one-cycle ACK, and there is no timeout.
interface intr_sched_if #(
  parameter int NSRC    = 3,
  parameter int NUMBITS = 4
);
  logic [NSRC-1:0]    IRQ;
  logic [NSRC-1:0]    IRQMASK;
  logic               IE;
  logic               ACK;
  logic               RETI;
  logic               STALL;
  logic               INTREQ;
  logic [NUMBITS-1:0] INTNUM;
  logic [NSRC-1:0]    PEND;
  logic               BUSY;
  logic [1:0]         state_dbg;

  modport slave (
    input  IRQ, IRQMASK, IE, ACK, RETI,
    output STALL, INTREQ, INTNUM, PEND, BUSY, state_dbg
  );

  modport master (
    output IRQ, IRQMASK, IE, ACK, RETI,
    input  STALL, INTREQ, INTNUM, PEND, BUSY, state_dbg
  );
endinterface

// File: rtl/intr_sched.sv
// Interrupt scheduler: edge-captured pending events, pipeline drain, INTREQ/ACK redirect, RETI unmask.
// Define INTR_SCHED_RR_EN for round-robin arbitration; by default the lowest index wins.
module intr_sched #(
  parameter int NSRC      = 3,
  parameter int DRAIN_CYC = 3,
  parameter int NUMBITS   = 4
) (
  input  logic       CLK,
  input  logic       INIT,
  intr_sched_if.slave bus
);

  localparam int CW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;

  if (DRAIN_CYC < 1) begin : g_bad_drain
    $error("intr_sched: DRAIN_CYC must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRAIN   = 2'd1,
    S_REQ     = 2'd2,
    S_SERVICE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUMBITS-1:0] num_q, num_d;
  logic [NSRC-1:0]    pend_q, pend_clr;
  logic [NSRC-1:0]    irq_q;
  logic [NSRC-1:0]    rise;
  logic [NSRC-1:0]    elig;
  logic [IW-1:0]      win_idx;

  assign rise = bus.IRQ & ~irq_q;
  assign elig = pend_q & bus.IRQMASK;

`ifdef INTR_SCHED_RR_EN
  logic [IW-1:0] ptr_q, ptr_d;

  // Scan starts just after the last granted source and wraps around.
  always_comb begin
    int  idx;
    logic found;
    idx     = 0;
    found   = 1'b0;
    win_idx = '0;
    for (int k = 1; k <= NSRC; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NSRC) idx = idx - NSRC;
      if (!found && elig[idx]) begin
        found   = 1'b1;
        win_idx = IW'(idx);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (INIT) ptr_q <= IW'(NSRC - 1);
    else      ptr_q <= ptr_d;
  end
`else
  always_comb begin
    win_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (elig[i]) win_idx = IW'(i);
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    num_d    = num_q;
    pend_clr = '0;
`ifdef INTR_SCHED_RR_EN
    ptr_d    = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.IE && (|elig)) begin
          num_d   = NUMBITS'(win_idx) + NUMBITS'(1);
          cnt_d   = CW'(DRAIN_CYC - 1);
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Dropping IE abandons the selection; the event stays pending.
        if (!bus.IE)              state_d = S_IDLE;
        else if (cnt_q == '0)     state_d = S_REQ;
        else                      cnt_d   = cnt_q - CW'(1);
      end
      S_REQ: begin
        if (bus.ACK) begin
          state_d = S_SERVICE;
          for (int i = 0; i < NSRC; i++) begin
            pend_clr[i] = (num_q == NUMBITS'(i + 1));
          end
`ifdef INTR_SCHED_RR_EN
          ptr_d = IW'(num_q - NUMBITS'(1));
`endif
        end
      end
      S_SERVICE: begin
        if (bus.RETI) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (INIT) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      num_q   <= '1;
      pend_q  <= '0;
      irq_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      // A fresh edge on the bit being acknowledged keeps it pending.
      pend_q  <= (pend_q & ~pend_clr) | rise;
      irq_q   <= bus.IRQ;
    end
  end

  assign bus.STALL     = (state_q == S_DRAIN) || (state_q == S_REQ);
  assign bus.INTREQ    = (state_q == S_REQ);
  assign bus.INTNUM    = (state_q == S_IDLE) ? '1 : num_q;
  assign bus.PEND      = pend_q;
  assign bus.BUSY      = (state_q != S_IDLE);
  assign bus.state_dbg = state_q;

endmodule
